// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and control FSM states for the
// sequential ALU (alu_seq, alu_shifter, alu_seq_if).
// Contents: op_t opcodes, state_t FSM enum, is_shift() helper.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t RST  = 3'b000;
  localparam op_t NOR  = 3'b001;
  localparam op_t ADD  = 3'b010;
  localparam op_t SUB  = 3'b011;
  localparam op_t SHL  = 3'b100;
  localparam op_t SHR  = 3'b101;
  localparam op_t LD   = 3'b110;
  localparam op_t ADDC = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic is_shift(op_t op);
    return (op == SHL) || (op == SHR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control unit and alu_seq.
// Ports: start/op/a/b driven by the master (control unit); busy/done/result/
// cout/zout/ovf driven by the slave (ALU).
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             start;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zout;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, zout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, zout, ovf
  );

endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: iterative one-bit-per-cycle shift register with down-counter.
// Ports: load (capture din/amount/dir), dir (0=left, 1=right), amount, din;
// busy (count non-zero), last (final shift this cycle), data, carry_out.
module alu_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dir,
  input  logic [SHW-1:0]   amount,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] data,
  output logic             carry_out
);

  logic [SHW-1:0] cnt;
  logic           dir_q;

  assign busy = (cnt != '0);
  assign last = (cnt == SHW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      cnt       <= '0;
      dir_q     <= 1'b0;
      carry_out <= 1'b0;
    end else if (load) begin
      data      <= din;
      cnt       <= amount;
      dir_q     <= dir;
      carry_out <= 1'b0;
    end else if (busy) begin
      // carry_out ends up holding the last bit that fell off the end
      if (dir_q) begin
        data      <= {1'b0, data[WIDTH-1:1]};
        carry_out <= data[0];
      end else begin
        data      <= {data[WIDTH-2:0], 1'b0};
        carry_out <= data[WIDTH-1];
      end
      cnt <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with carry/zero flags and iterative shifts.
// Ports: clk, rst (async, active-high), bus (alu_seq_if.slave): start/op/a/b
// in; busy/done/result/cout/zout/ovf out. ovf logic built only with ALU_OVF_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  state_t           state_q, state_d;
  logic             busy, accept, long_shift, sh_load;
  logic             sh_busy, sh_last, sh_carry;
  logic [WIDTH-1:0] sh_data;

  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             vld_q;   // an operation completes on the next edge
  logic             sh_q;    // that completion comes from the shifter

  logic [WIDTH-1:0] result_q, res_d;
  logic             cout_q, cout_d, zout_q, done_q;
  logic [WIDTH:0]   sum, diff;

  assign busy       = (state_q == SHIFT);
  assign accept     = bus.start && !busy;
  // shifts by zero take the single-cycle path
  assign long_shift = is_shift(bus.op) && (bus.b[SHW-1:0] != '0);

  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .dir       (bus.op == SHR),
    .amount    (bus.b[SHW-1:0]),
    .din       (bus.a),
    .busy      (sh_busy),
    .last      (sh_last),
    .data      (sh_data),
    .carry_out (sh_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sh_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && long_shift) begin
          sh_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sh_last || !sh_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured at acceptance so later input changes are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= RST;
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
      sh_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      vld_q <= (accept && !long_shift) || (busy && sh_last);
      sh_q  <= busy && sh_last;
    end
  end

  // ADDC folds in the carry flag as it stands when the op executes, i.e. the
  // carry left by the previously completed operation.
  assign sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, (op_q == ADDC) && cout_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    case (op_q)
      RST:      res_d = '0;
      NOR:      res_d = ~(a_q | b_q);
      ADD:      {cout_d, res_d} = sum;
      ADDC:     {cout_d, res_d} = sum;
      SUB:      {cout_d, res_d} = diff;
      SHL, SHR: begin
        if (sh_q) begin
          res_d  = sh_data;
          cout_d = sh_carry;
        end else begin
          res_d  = a_q;
        end
      end
      LD:       res_d = a_q;
      default:  res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zout_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= vld_q;
      if (vld_q) begin
        result_q <= res_d;
        cout_q   <= cout_d;
        zout_q   <= (res_d == '0);
      end
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    case (op_q)
      ADD, ADDC: ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      SUB:       ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      default:   ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ovf_q <= 1'b0;
    else if (vld_q) ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zout   = zout_q;

endmodule
